// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stall, flush and redirect strobes from stage hazards.
// Latency: Mealy outputs from registered state plus current inputs. Backpressure: memory waits freeze the pipe, and a load-use hazard inserts one bubble.
module hazard_ctrl #(
    parameter int unsigned STARTUP_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT    = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       decode_rs1,
    input  logic [4:0]       decode_rs2,
    input  logic             decode_uses_rs1,
    input  logic             decode_uses_rs2,
    input  logic             decode_jump,
    input  logic [4:0]       execute_rd,
    input  logic             execute_is_load,
    input  logic             execute_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_execute,
    output logic             stall_memory,
    output logic             flush_decode,
    output logic             flush_execute,
    output logic             flush_wb,
    output logic             redirect_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        LOAD_STALL = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    localparam logic [7:0]  HOLD_INIT = 8'(STARTUP_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mw, rd, lu, jp;

    always_comb begin
        mw = mem_req & ~mem_ready;
        rd = execute_redirect;
        jp = decode_jump;
        lu = execute_is_load & (execute_rd != 5'd0) &
             ((decode_uses_rs1 & (decode_rs1 == execute_rd)) |
              (decode_uses_rs2 & (decode_rs2 == execute_rd)));
    end

    always_comb begin
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        stall_memory  = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        flush_wb      = 1'b0;
        redirect_en   = 1'b0;
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_count_d = stall_count_q;

        case (state_q)
            RESET_HOLD: begin
                stall_fetch   = 1'b1;
                flush_decode  = 1'b1;
                flush_execute = 1'b1;
                flush_wb      = 1'b1;
                if (hold_cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end

            RUN, LOAD_STALL: begin
                state_d = RUN;
                if (mw) begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    stall_execute = 1'b1;
                    stall_memory  = 1'b1;
                    flush_wb      = 1'b1;
                    state_d       = MEM_WAIT;
                    wait_cnt_d    = 16'd1;
                end else if (rd) begin
                    // Decode holds a wrong-path instruction, so its load-use or jump is moot.
                    flush_decode  = 1'b1;
                    flush_execute = 1'b1;
                    redirect_en   = 1'b1;
                end else if (lu && (state_q == RUN)) begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    flush_execute = 1'b1;
                    state_d       = LOAD_STALL;
                end else if (jp) begin
                    flush_decode = 1'b1;
                    redirect_en  = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (!mem_ready) begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    stall_execute = 1'b1;
                    stall_memory  = 1'b1;
                    flush_wb      = 1'b1;
                    if (wait_cnt_q >= WAIT_LAST) begin
                        // The access is abandoned and the pipe is released.
                        mem_timeout_d = 1'b1;
                        wait_cnt_d    = 16'd0;
                        state_d       = RUN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    wait_cnt_d = 16'd0;
                    state_d    = RUN;
                    if (rd) begin
                        flush_decode  = 1'b1;
                        flush_execute = 1'b1;
                        redirect_en   = 1'b1;
                    end else if (jp) begin
                        flush_decode = 1'b1;
                        redirect_en  = 1'b1;
                    end
                end
            end

            default: state_d = RESET_HOLD;
        endcase

        if (stall_fetch && (state_q != RESET_HOLD) && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RESET_HOLD;
            hold_cnt_q    <= HOLD_INIT;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a main instance plus a narrow-counter instance for saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] decode_rs1, decode_rs2, execute_rd;
    logic       decode_uses_rs1, decode_uses_rs2, decode_jump;
    logic       execute_is_load, execute_redirect, mem_req, mem_ready;

    logic        stall_fetch, stall_decode, stall_execute, stall_memory;
    logic        flush_decode, flush_execute, flush_wb, redirect_en;
    logic        mem_timeout;
    logic [15:0] stall_count;
    logic [1:0]  state;

    logic        s_stall_fetch, s_stall_decode, s_stall_execute, s_stall_memory;
    logic        s_flush_decode, s_flush_execute, s_flush_wb, s_redirect_en;
    logic        s_mem_timeout;
    logic [3:0]  s_stall_count;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    // Strobe bit order: sf sd se sm fd fe fw re
    localparam logic [7:0] S_RST = 8'h8E;
    localparam logic [7:0] S_FRZ = 8'hF2;
    localparam logic [7:0] S_RD  = 8'h0D;
    localparam logic [7:0] S_LU  = 8'hC4;
    localparam logic [7:0] S_JP  = 8'h09;
    localparam logic [7:0] S_NON = 8'h00;

    wire [7:0] strobes = {stall_fetch, stall_decode, stall_execute, stall_memory,
                          flush_decode, flush_execute, flush_wb, redirect_en};

    hazard_ctrl #(.STARTUP_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
        .decode_uses_rs1(decode_uses_rs1), .decode_uses_rs2(decode_uses_rs2),
        .decode_jump(decode_jump), .execute_rd(execute_rd),
        .execute_is_load(execute_is_load), .execute_redirect(execute_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .stall_memory(stall_memory),
        .flush_decode(flush_decode), .flush_execute(flush_execute),
        .flush_wb(flush_wb), .redirect_en(redirect_en),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .state(state)
    );

    hazard_ctrl #(.STARTUP_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
        .decode_uses_rs1(decode_uses_rs1), .decode_uses_rs2(decode_uses_rs2),
        .decode_jump(decode_jump), .execute_rd(execute_rd),
        .execute_is_load(execute_is_load), .execute_redirect(execute_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_fetch(s_stall_fetch), .stall_decode(s_stall_decode),
        .stall_execute(s_stall_execute), .stall_memory(s_stall_memory),
        .flush_decode(s_flush_decode), .flush_execute(s_flush_execute),
        .flush_wb(s_flush_wb), .redirect_en(s_redirect_en),
        .mem_timeout(s_mem_timeout), .stall_count(s_stall_count), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, leaving time 1 unit past the edge; a further #1 lets new inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        decode_rs1 = 5'd0; decode_rs2 = 5'd0; execute_rd = 5'd0;
        decode_uses_rs1 = 1'b0; decode_uses_rs2 = 1'b0; decode_jump = 1'b0;
        execute_is_load = 1'b0; execute_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2 rst = 1'b0;
        #1;
        chk("rst_strobes", strobes, S_RST);
        chk("rst_state", state, 2'd0);
        chk("rst_count", stall_count, 0);
        chk("rst_timeout", mem_timeout, 0);
        tick(); tick();
        chk("rst_held_state", state, 2'd0);

        // 1: startup hold of exactly four cycles after release
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("hold_state_%0d", i), state, 2'd0);
            chk($sformatf("hold_strobes_%0d", i), strobes, S_RST);
            tick();
        end
        #1;
        chk("run_after_hold", state, 2'd1);
        chk("run_idle_strobes", strobes, S_NON);
        chk("hold_not_counted", stall_count, 0);

        // 2: load-use on rs1, one bubble only
        execute_is_load = 1'b1; execute_rd = 5'd5;
        decode_uses_rs1 = 1'b1; decode_rs1 = 5'd5; decode_rs2 = 5'd1; decode_uses_rs2 = 1'b1;
        #1;
        chk("lu_rs1_strobes", strobes, S_LU);
        tick(); #1;
        chk("lu_state", state, 2'd2);
        chk("lu_second_cycle", strobes, S_NON);
        tick(); #1;
        chk("lu_back_run", state, 2'd1);
        chk("lu_count", stall_count, 1);
        execute_rd = 5'd0; decode_rs1 = 5'd0;
        #1;
        chk("lu_x0_no_stall", strobes, S_NON);
        execute_rd = 5'd7; decode_rs1 = 5'd7; decode_uses_rs1 = 1'b0;
        decode_rs2 = 5'd3;
        #1;
        chk("lu_unused_rs1", strobes, S_NON);
        decode_rs2 = 5'd7;
        #1;
        chk("lu_rs2_strobes", strobes, S_LU);
        tick();
        clear_inputs();
        tick(); #1;
        chk("lu_rs2_count", stall_count, 2);

        // 3: redirect beats load-use; decode jump alone
        execute_is_load = 1'b1; execute_rd = 5'd9;
        decode_uses_rs1 = 1'b1; decode_rs1 = 5'd9; execute_redirect = 1'b1; decode_jump = 1'b1;
        #1;
        chk("rd_over_lu_strobes", strobes, S_RD);
        tick(); #1;
        chk("rd_over_lu_state", state, 2'd1);
        clear_inputs();
        decode_jump = 1'b1;
        #1;
        chk("jp_strobes", strobes, S_JP);
        tick();
        clear_inputs();
        #1;
        chk("jp_no_count", stall_count, 2);

        // 4: three-cycle memory wait with a redirect held in execute
        mem_req = 1'b1; mem_ready = 1'b0; execute_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_strobes_%0d", i), strobes, S_FRZ);
            tick();
        end
        #1;
        chk("mw_state", state, 2'd3);
        mem_ready = 1'b1;
        #1;
        chk("mw_release_strobes", strobes, S_RD);
        tick();
        clear_inputs();
        #1;
        chk("mw_release_state", state, 2'd1);
        chk("mw_count", stall_count, 5);

        // 5: timeout after eight stalled cycles, then reset mid-wait
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to_pending_%0d", i), mem_timeout, 0);
            tick();
        end
        #1;
        chk("to_flag", mem_timeout, 1);
        chk("to_state_run", state, 2'd1);
        chk("to_count", stall_count, 13);
        tick(); tick(); #1;
        chk("to_sticky", mem_timeout, 1);
        chk("to_rewait_state", state, 2'd3);
        rst = 1'b0;
        #1;
        chk("midrst_state", state, 2'd0);
        chk("midrst_timeout", mem_timeout, 0);
        chk("midrst_count", stall_count, 0);
        chk("midrst_strobes", strobes, S_RST);

        // 6: continuous stalls saturate the narrow counter
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("sat_at_15", s_stall_count, 15);
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("sat_hold", s_stall_count, 15);
        chk("wide_count", stall_count, 21);
        chk("sat_timeout", s_mem_timeout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core (fetch, decode, execute, memory, writeback). It takes hazard indications from the stages and drives per-stage stall/flush strobes and the PC-redirect enable.
- Load-use hazards: inserts one bubble.
- Taken branches / jumps: flushes the wrong path.
- Multi-cycle data-memory accesses: freezes the pipe.
- After reset release: holds fetch for a fixed number of cycles.
It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
STARTUP_CYCLES, 4, cycles fetch is held after reset release; legal range 1..255.
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before timeout; legal range 2..65535.
CNT_W, 16, width of stall_count.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
decode_rs1  in  5  rs1 of instruction in decode
decode_rs2  in  5  rs2 of instruction in decode
decode_uses_rs1  in  1  decode instruction reads rs1
decode_uses_rs2  in  1  decode instruction reads rs2
decode_jump  in  1  jal resolved in decode
execute_rd  in  5  rd of instruction in execute
execute_is_load  in  1  execute instruction is a load (result_src==2'b01)
execute_redirect  in  1  taken branch or jalr resolved in execute
mem_req  in  1  memory stage issuing a data access this cycle
mem_ready  in  1  data memory completes access this cycle
stall_fetch  out  1  hold PC and fetch register
stall_decode  out  1  hold decode pipeline register
stall_execute  out  1  hold execute pipeline register
stall_memory  out  1  hold memory pipeline register
flush_decode  out  1  load bubble into decode register
flush_execute  out  1  load bubble into execute register
flush_wb  out  1  load bubble into writeback register
redirect_en  out  1  permit fetch to take branch/jump target
mem_timeout  out  1  sticky error: MEM_TIMEOUT exceeded
stall_count  out  CNT_W  saturating count of stall cycles
state  out  2  0 RESET_HOLD, 1 RUN, 2 LOAD_STALL, 3 MEM_WAIT

Behaviour:
- Outputs are combinational from the registered state plus the current inputs (Mealy). state, hold counter, wait counter, mem_timeout and stall_count are registers.
- Reset (rst=0, asynchronous):
  - state=RESET_HOLD, hold counter=STARTUP_CYCLES-1, wait counter=0, mem_timeout=0, stall_count=0.
  - While asserted, outputs are stall_fetch=1, flush_decode=flush_execute=flush_wb=1, all others 0.
  - Reset asserted mid-operation aborts any state immediately.
- RESET_HOLD:
  - Outputs as above; all inputs ignored.
  - The counter decrements each cycle; at 0, next state is RUN. Fetch is therefore held for exactly STARTUP_CYCLES cycles after rst rises.
- Hazard conditions:
  - mw = mem_req & ~mem_ready.
  - rd = execute_redirect.
  - lu = execute_is_load & execute_rd!=0 & ((decode_uses_rs1 & decode_rs1==execute_rd) | (decode_uses_rs2 & decode_rs2==execute_rd)).
  - jp = decode_jump.
- RUN, priority mw > rd > lu > jp:
  - mw: stall_fetch/decode/execute/memory=1, flush_wb=1, redirect_en=0; next MEM_WAIT, wait counter=1.
  - rd: flush_decode=flush_execute=1, redirect_en=1; stay RUN. Any lu/jp in the same cycle is discarded, since the decode instruction is wrong-path.
  - lu: stall_fetch=stall_decode=1, flush_execute=1; next LOAD_STALL.
  - jp: flush_decode=1, redirect_en=1; stay RUN.
  - none: all outputs 0.
- LOAD_STALL:
  - Exactly one bubble per load: lu is ignored this cycle.
  - mw, rd and jp are evaluated as in RUN. If none apply, outputs are 0.
  - Next state is RUN, or MEM_WAIT if mw.
- MEM_WAIT:
  - While mem_ready=0: same outputs as the mw entry; wait counter increments.
  - When the counter reaches MEM_TIMEOUT: set mem_timeout=1, force next state RUN (pipe released, access abandoned), clear the counter.
  - When mem_ready=1: all stalls deassert in that same cycle; rd/jp are evaluated as in RUN; next RUN.
  - A redirect held in execute during the wait is acted on in the release cycle.
- stall_count: +1 every cycle with stall_fetch=1 and state!=RESET_HOLD; saturates at all-ones.
- mem_timeout: cleared only by reset.

Test Plan:
1. Reset release with STARTUP_CYCLES=4 -> stall_fetch=1 for exactly 4 cycles after rst rises, state RUN on cycle 5, stall_count=0.
2. lw x5 in execute, decode add x6,x5,x1 (uses_rs1, rs1=5) -> one cycle of stall_fetch=stall_decode=flush_execute=1, next cycle all 0, stall_count=1. Repeat with execute_rd=0 -> no stall.
3. Load-use plus execute_redirect in the same cycle -> flush_decode=flush_execute=redirect_en=1, no stall, state stays RUN.
4. mem_req=1, mem_ready low for 3 cycles then high -> stalls 1 for 3 cycles, released the cycle mem_ready=1; execute_redirect held through the wait -> redirect_en=1 only in the release cycle; stall_count=3.
5. MEM_TIMEOUT=8, mem_ready never asserted -> mem_timeout rises after 8 wait cycles and stays 1, state returns RUN; assert rst mid-MEM_WAIT -> state=RESET_HOLD immediately, mem_timeout=0.
6. Force 2^CNT_W+5 stall cycles (CNT_W=4 build) -> stall_count holds at 15.
